pulse_interval_monitor: RTL

Downstream consumer of the random pulse generator's output. Detects rising edges on the pulse stream and measures them over fixed-length windows: pulse count, and minimum, maximum and last inter-pulse interval. At each window end the results are snapshotted into shadow registers. A byte-wide select/readout port exposes the snapshot on a tt_um-style 8-bit output, so pulse statistics can be checked on silicon.

---
 rtl/pulse_interval_monitor.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pulse_interval_monitor.sv
// Rising-edge statistics over fixed windows of enabled cycles: pulse count plus
// min/max/last inter-pulse interval, snapshotted each window and read out bytewise.
module pulse_interval_monitor #(
    parameter int WINDOW_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pulse_in,
    input  logic       clear,
    input  logic [2:0] sel,
    output logic [7:0] data_out,
    output logic       win_done,
    output logic       overflow
);

    localparam int WinW = $clog2(WINDOW_LEN);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_LEN - 1);

    logic            pulse_q;
    logic [15:0]     ivlCnt_q, ivlCnt_d;
    logic [WinW-1:0] winCnt_q, winCnt_d;
    logic [15:0]     liveCount_q, liveCount_d;
    logic [15:0]     liveMin_q, liveMin_d;
    logic [15:0]     liveMax_q, liveMax_d;
    logic [7:0]      liveLast_q, liveLast_d;
    logic            armed_q, armed_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     shCount_q, shCount_d;
    logic [15:0]     shMin_q, shMin_d;
    logic [15:0]     shMax_q, shMax_d;
    logic [7:0]      shLast_q, shLast_d;
    logic [7:0]      dataOut_q, dataOut_d;

    logic        rise;
    logic        winEnd;
    logic        ivlSat;
    logic [15:0] interval;

    assign rise     = ena & pulse_in & ~pulse_q;
    assign winEnd   = ena & (winCnt_q == WinLast);
    assign ivlSat   = &ivlCnt_q;
    assign interval = ivlSat ? 16'hFFFF : ivlCnt_q + 16'd1;

    // Only the low byte of the last interval is ever read out, so only that is kept.
    always_comb begin
        ivlCnt_d    = ivlCnt_q;
        winCnt_d    = winCnt_q;
        liveCount_d = liveCount_q;
        liveMin_d   = liveMin_q;
        liveMax_d   = liveMax_q;
        liveLast_d  = liveLast_q;
        armed_d     = armed_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q;
        shCount_d   = shCount_q;
        shMin_d     = shMin_q;
        shMax_d     = shMax_q;
        shLast_d    = shLast_q;

        if (ena) begin
            winCnt_d = winEnd ? '0 : winCnt_q + WinW'(1);
            if (rise) begin
                ivlCnt_d = '0;
            end else if (!ivlSat) begin
                ivlCnt_d = ivlCnt_q + 16'd1;
            end

            if (rise) begin
                armed_d = 1'b1;
                if (&liveCount_q) begin
                    overflow_d = 1'b1;
                end else begin
                    liveCount_d = liveCount_q + 16'd1;
                end
                if (armed_q) begin
                    if (interval < liveMin_q) liveMin_d = interval;
                    if (interval > liveMax_q) liveMax_d = interval;
                    liveLast_d = interval[7:0];
                    if (ivlSat) overflow_d = 1'b1;
                end
            end

            // The snapshot takes the updated live values so a last-cycle rise is included.
            if (winEnd) begin
                shCount_d   = liveCount_d;
                shMin_d     = liveMin_d;
                shMax_d     = liveMax_d;
                shLast_d    = liveLast_d;
                valid_d     = 1'b1;
                liveCount_d = '0;
                liveMin_d   = 16'hFFFF;
                liveMax_d   = '0;
                liveLast_d  = '0;
            end
        end

        if (clear) begin
            ivlCnt_d    = '0;
            winCnt_d    = '0;
            liveCount_d = '0;
            liveMin_d   = 16'hFFFF;
            liveMax_d   = '0;
            liveLast_d  = '0;
            armed_d     = 1'b0;
            valid_d     = 1'b0;
            overflow_d  = 1'b0;
            shCount_d   = '0;
            shMin_d     = 16'hFFFF;
            shMax_d     = '0;
            shLast_d    = '0;
        end
    end

    always_comb begin
        dataOut_d = 8'h00;
        case (sel)
            3'd0: dataOut_d = shCount_q[7:0];
            3'd1: dataOut_d = shCount_q[15:8];
            3'd2: dataOut_d = shMin_q[7:0];
            3'd3: dataOut_d = shMin_q[15:8];
            3'd4: dataOut_d = shMax_q[7:0];
            3'd5: dataOut_d = shMax_q[15:8];
            3'd6: dataOut_d = shLast_q;
            3'd7: dataOut_d = {overflow_q, valid_q, 6'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q     <= 1'b0;
            ivlCnt_q    <= '0;
            winCnt_q    <= '0;
            liveCount_q <= '0;
            liveMin_q   <= 16'hFFFF;
            liveMax_q   <= '0;
            liveLast_q  <= '0;
            armed_q     <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            shCount_q   <= '0;
            shMin_q     <= 16'hFFFF;
            shMax_q     <= '0;
            shLast_q    <= '0;
            dataOut_q   <= '0;
        end else begin
            pulse_q     <= pulse_in;
            ivlCnt_q    <= ivlCnt_d;
            winCnt_q    <= winCnt_d;
            liveCount_q <= liveCount_d;
            liveMin_q   <= liveMin_d;
            liveMax_q   <= liveMax_d;
            liveLast_q  <= liveLast_d;
            armed_q     <= armed_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            shCount_q   <= shCount_d;
            shMin_q     <= shMin_d;
            shMax_q     <= shMax_d;
            shLast_q    <= shLast_d;
            dataOut_q   <= dataOut_d;
        end
    end

    assign data_out = dataOut_q;
    assign win_done = winEnd & ~clear;
    assign overflow = overflow_q;

endmodule
